// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the ss/bdone bus and its two-master arbiter.
package bus_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} mst_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: saturating stall counter that flags the last permitted BUSY cycle.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] SAT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : (count_en && cnt_q != SAT) ? cnt_q + 1'b1 : cnt_q;
  assign expire = TIMEOUT_CYCLES != 0 && count_en && cnt_q == LAST;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one ss/bdone slave between m0 (LSU) and m1 (fetch) with a hung-slave watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ss,
  input  ttype_t            m0_ttype,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_bdone,
  output logic              m0_berr,
  input  logic              m1_ss,
  input  ttype_t            m1_ttype,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_bdone,
  output logic              m1_berr,
  output logic              s_ss,
  output ttype_t            s_ttype,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_bdone,
  output logic [1:0]        grant
);
  arb_state_t state_q, state_d;
  mst_t owner_q, owner_d, last_q, last_d, pick;
  logic busy, m1_own, owner_ss, done, abort, fin, expire;
  assign busy = state_q == BUSY;
  assign m1_own = owner_q == M1;
  assign owner_ss = m1_own ? m1_ss : m0_ss;
  assign s_ss = busy && owner_ss;
  // normal completion beats a coincident watchdog expiry
  assign done = s_ss && s_bdone;
  assign abort = s_ss && !s_bdone && expire;
  assign fin = done || abort;
  assign s_ttype = !busy ? READ : m1_own ? m1_ttype : m0_ttype;
  assign s_addr = !busy ? '0 : m1_own ? m1_addr : m0_addr;
  assign s_wdata = !busy ? '0 : m1_own ? m1_wdata : m0_wdata;
  assign grant = !busy ? 2'b00 : m1_own ? 2'b10 : 2'b01;
  assign m0_bdone = fin && !m1_own;
  assign m1_bdone = fin && m1_own;
  assign m0_berr = abort && !m1_own;
  assign m1_berr = abort && m1_own;
  assign m0_rdata = (done && !m1_own) ? s_rdata : '0;
  assign m1_rdata = (done && m1_own) ? s_rdata : '0;
  assign pick = (m0_ss && m1_ss) ? ((RR && last_q == M0) ? M1 : M0) : (m1_ss ? M1 : M0);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    if (!busy && (m0_ss || m1_ss)) begin
      state_d = BUSY;
      owner_d = pick;
      last_d = pick;
    end else if (busy && (!owner_ss || fin)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q <= M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
  end
  bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clear(!busy),
    .count_en(busy && owner_ss && !s_bdone),
    .expire(expire)
  );
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench over RR, fixed-priority and short-watchdog arbiters.
module tb_bus_arbiter;
  import bus_pkg::*;
  typedef struct packed {
    logic s_ss;
    logic [1:0] grant;
    logic b0, b1, e0, e1;
    logic [31:0] r0, r1;
    logic t;
    logic [31:0] a, w;
  } obs_t;
  typedef struct {
    string tag;
    int d;
    obs_t v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_ss = 1'b0, m1_ss = 1'b0, s_bdone = 1'b0;
  ttype_t m0_ttype = READ, m1_ttype = READ;
  logic [31:0] m0_addr = 32'h0200_4000, m1_addr = 32'h8000_0100;
  logic [31:0] m0_wdata = 32'h64, m1_wdata = 32'h99, s_rdata = '0;
  logic s_ss_w[3], b0_w[3], b1_w[3], e0_w[3], e1_w[3];
  ttype_t t_w[3];
  logic [1:0] g_w[3];
  logic [31:0] r0_w[3], r1_w[3], a_w[3], wd_w[3];
  exp_t sb[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  // instance 0: round-robin, 1: fixed priority, 2: round-robin with 4-cycle watchdog
  bus_arbiter #(.RR(1'b1), .TIMEOUT_CYCLES(255)) u_rr (
    .clk(clk), .rst(rst),
    .m0_ss(m0_ss), .m0_ttype(m0_ttype), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(r0_w[0]), .m0_bdone(b0_w[0]), .m0_berr(e0_w[0]),
    .m1_ss(m1_ss), .m1_ttype(m1_ttype), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(r1_w[0]), .m1_bdone(b1_w[0]), .m1_berr(e1_w[0]),
    .s_ss(s_ss_w[0]), .s_ttype(t_w[0]), .s_addr(a_w[0]), .s_wdata(wd_w[0]),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .grant(g_w[0])
  );
  bus_arbiter #(.RR(1'b0), .TIMEOUT_CYCLES(255)) u_fp (
    .clk(clk), .rst(rst),
    .m0_ss(m0_ss), .m0_ttype(m0_ttype), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(r0_w[1]), .m0_bdone(b0_w[1]), .m0_berr(e0_w[1]),
    .m1_ss(m1_ss), .m1_ttype(m1_ttype), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(r1_w[1]), .m1_bdone(b1_w[1]), .m1_berr(e1_w[1]),
    .s_ss(s_ss_w[1]), .s_ttype(t_w[1]), .s_addr(a_w[1]), .s_wdata(wd_w[1]),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .grant(g_w[1])
  );
  bus_arbiter #(.RR(1'b1), .TIMEOUT_CYCLES(4)) u_wd (
    .clk(clk), .rst(rst),
    .m0_ss(m0_ss), .m0_ttype(m0_ttype), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(r0_w[2]), .m0_bdone(b0_w[2]), .m0_berr(e0_w[2]),
    .m1_ss(m1_ss), .m1_ttype(m1_ttype), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(r1_w[2]), .m1_bdone(b1_w[2]), .m1_berr(e1_w[2]),
    .s_ss(s_ss_w[2]), .s_ttype(t_w[2]), .s_addr(a_w[2]), .s_wdata(wd_w[2]),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .grant(g_w[2])
  );
  function automatic obs_t get(int d);
    obs_t o;
    o = '{s_ss_w[d], g_w[d], b0_w[d], b1_w[d], e0_w[d], e1_w[d], r0_w[d], r1_w[d], t_w[d], a_w[d], wd_w[d]};
    return o;
  endfunction
  function automatic obs_t idle_o();
    obs_t o;
    o = '0;
    return o;
  endfunction
  function automatic obs_t busy_o(int who, logic b, logic e, logic [31:0] r);
    obs_t o;
    o = '0;
    o.s_ss = 1'b1;
    o.grant = who == 1 ? 2'b10 : 2'b01;
    o.t = who == 1 ? m1_ttype : m0_ttype;
    o.a = who == 1 ? m1_addr : m0_addr;
    o.w = who == 1 ? m1_wdata : m0_wdata;
    if (who == 1) begin
      o.b1 = b; o.e1 = e; o.r1 = r;
    end else begin
      o.b0 = b; o.e0 = e; o.r0 = r;
    end
    return o;
  endfunction
  task automatic ex(input string tag, input int d, input obs_t v);
    sb.push_back('{tag, d, v});
  endtask
  task automatic tick();
    exp_t e;
    obs_t o;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = get(e.d);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s dut%0d: observed %h expected %h", e.tag, e.d, o, e.v);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    m0_ss = 1'b0;
    m1_ss = 1'b0;
    s_bdone = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) ex("reset", d, idle_o());
    tick();
  endtask
  initial begin
    @(posedge clk);
    rst_pulse();
    // single m0 write, zero-wait slave
    m0_ttype = WRITE; m0_ss = 1'b1; s_bdone = 1'b1; s_rdata = 32'h1234;
    ex("wr_c0", 0, idle_o()); tick();
    ex("wr_c1", 0, busy_o(0, 1'b1, 1'b0, 32'h1234)); tick();
    m0_ss = 1'b0;
    ex("wr_c2", 0, idle_o()); tick();
    // both masters reading continuously: RR alternates, fixed priority starves m1
    rst_pulse();
    m0_ttype = READ; m1_ttype = READ; m0_ss = 1'b1; m1_ss = 1'b1; s_bdone = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s_rdata = c == 1 ? 32'hAAAA_0000 : c == 3 ? 32'h5555_0000 : 32'h100 + 32'(c);
      if (c % 2 == 0) begin
        ex("rr_idle", 0, idle_o());
        ex("fp_idle", 1, idle_o());
      end else begin
        ex("rr_grant", 0, busy_o((c >> 1) & 1, 1'b1, 1'b0, s_rdata));
        ex("fp_grant", 1, busy_o(0, 1'b1, 1'b0, s_rdata));
      end
      tick();
    end
    m0_ss = 1'b0; m1_ss = 1'b0;
    ex("rr_end", 0, idle_o()); tick();
    // slow slave completes on 4th BUSY cycle while m1 waits and toggles
    rst_pulse();
    m1_ttype = WRITE; m0_ss = 1'b1;
    ex("wait_c0", 0, idle_o()); tick();
    m1_ss = 1'b1;
    ex("wait_c1", 0, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    m1_ss = 1'b0;
    ex("wait_c2", 0, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    m1_ss = 1'b1;
    ex("wait_c3", 0, busy_o(0, 1'b0, 1'b0, 32'h0));
    ex("wd_c3", 2, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    s_bdone = 1'b1; s_rdata = 32'hCAFE_F00D;
    ex("wait_c4", 0, busy_o(0, 1'b1, 1'b0, 32'hCAFE_F00D));
    ex("wd_race", 2, busy_o(0, 1'b1, 1'b0, 32'hCAFE_F00D)); tick();
    m0_ss = 1'b0; s_bdone = 1'b0;
    ex("wait_c5", 0, idle_o()); tick();
    s_bdone = 1'b1; s_rdata = 32'h1357;
    ex("wait_c6", 0, busy_o(1, 1'b1, 1'b0, 32'h1357)); tick();
    m1_ss = 1'b0;
    ex("wait_c7", 0, idle_o()); tick();
    // hung slave: watchdog aborts on BUSY cycle 4; RR owner then drops ss
    rst_pulse();
    m0_ss = 1'b1; s_rdata = 32'hDEAD_BEEF;
    ex("to_c0", 2, idle_o()); tick();
    for (int c = 1; c < 4; c++) begin
      ex("to_busy", 2, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    end
    ex("to_abort", 2, busy_o(0, 1'b1, 1'b1, 32'h0));
    ex("rr_nowd", 0, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    m0_ss = 1'b0;
    ex("to_c5", 2, idle_o());
    begin
      obs_t o;
      o = busy_o(0, 1'b0, 1'b0, 32'h0);
      o.s_ss = 1'b0;
      ex("drop_ss", 0, o);
    end
    tick();
    m0_ss = 1'b1; m1_ss = 1'b1;
    ex("drop_idle", 0, idle_o()); tick();
    s_bdone = 1'b1; s_rdata = 32'h2468;
    ex("drop_last", 0, busy_o(1, 1'b1, 1'b0, 32'h2468)); tick();
    // reset pulse in the middle of a BUSY transaction
    rst_pulse();
    m1_ttype = READ; m0_ss = 1'b1; m1_ss = 1'b1;
    ex("mr_c0", 0, idle_o()); tick();
    ex("mr_c1", 0, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    rst = 1'b1;
    ex("mr_c2", 0, busy_o(0, 1'b0, 1'b0, 32'h0)); tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) ex("mr_abort", d, idle_o());
    tick();
    s_bdone = 1'b1; s_rdata = 32'h7777;
    ex("mr_tie", 0, busy_o(0, 1'b1, 1'b0, 32'h7777)); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
